// File: rtl/uart_rx.sv
// Asynchronous serial receiver: start, WORD_WIDTH data bits LSB first, parity, stop.
// Mid-bit sampling of a synchronised line, output held on a valid/ready register.
module uart_rx #(
  parameter int BAUD_RATE   = 115200,
  parameter int CLK_RATE    = 100000000,
  parameter int WORD_WIDTH  = 8,
  parameter int EVEN_PARITY = 0
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  rx_data_in,
  input  logic                  rx_ready,
  output logic [WORD_WIDTH-1:0] rx_data_out,
  output logic                  rx_data_valid,
  output logic                  rx_parity_err,
  output logic                  rx_frame_err,
  output logic                  rx_overrun,
  output logic                  rx_busy
);

  localparam int BIT_CNT  = CLK_RATE / BAUD_RATE;
  localparam int HALF_CNT = BIT_CNT / 2;
  localparam int BAUD_W   = (BIT_CNT > 1) ? $clog2(BIT_CNT) : 1;
  localparam int BITS_W   = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;

  localparam logic [BAUD_W-1:0] BIT_LAST  = BAUD_W'(BIT_CNT - 1);
  localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(HALF_CNT - 1);
  localparam logic [BITS_W-1:0] WORD_LAST = BITS_W'(WORD_WIDTH - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic                  sync1_q, sync1_d;
  logic                  sync2_q, sync2_d;
  logic                  prev_q, prev_d;
  logic [2:0]            state_q, state_d;
  logic [BAUD_W-1:0]     baud_q, baud_d;
  logic [BITS_W-1:0]     bits_q, bits_d;
  logic [WORD_WIDTH-1:0] shift_q, shift_d;
  logic                  par_err_q, par_err_d;
  logic [WORD_WIDTH-1:0] data_out_q, data_out_d;
  logic                  valid_q, valid_d;
  logic                  perr_q, perr_d;
  logic                  ferr_q, ferr_d;
  logic                  ovr_q, ovr_d;

  logic baud_tick;
  logic frame_done;
  logic exp_par;
  logic accept;

  always_comb begin
    sync1_d    = rx_data_in;
    sync2_d    = sync1_q;
    prev_d     = sync2_q;
    state_d    = state_q;
    baud_d     = baud_q;
    bits_d     = bits_q;
    shift_d    = shift_q;
    par_err_d  = par_err_q;
    frame_done = 1'b0;
    baud_tick  = (baud_q == BIT_LAST);
    exp_par    = (EVEN_PARITY != 0) ? ^shift_q : ~^shift_q;

    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (prev_q && !sync2_q) state_d = S_START;
      end
      S_START: begin
        if (baud_q == HALF_LAST) begin
          baud_d  = '0;
          bits_d  = '0;
          state_d = sync2_q ? S_IDLE : S_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_tick) begin
          baud_d  = '0;
          shift_d = {sync2_q, shift_q[WORD_WIDTH-1:1]};
          if (bits_q == WORD_LAST) state_d = S_PARITY;
          else bits_d = bits_q + 1'b1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_PARITY: begin
        if (baud_tick) begin
          baud_d    = '0;
          par_err_d = (sync2_q != exp_par);
          state_d   = S_STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_STOP: begin
        // Leave at mid-stop so a back-to-back start edge is not missed.
        if (baud_tick) begin
          baud_d     = '0;
          frame_done = 1'b1;
          state_d    = S_IDLE;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    accept     = valid_q && rx_ready;
    data_out_d = data_out_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    valid_d    = accept ? 1'b0 : valid_q;
    ovr_d      = accept ? 1'b0 : ovr_q;
    // A completing frame is dropped only if the held word is not leaving this cycle.
    if (frame_done) begin
      if (!valid_q || rx_ready) begin
        data_out_d = shift_q;
        perr_d     = par_err_q;
        ferr_d     = !sync2_q;
        valid_d    = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      prev_q     <= 1'b1;
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bits_q     <= '0;
      shift_q    <= '0;
      par_err_q  <= 1'b0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prev_q     <= prev_d;
      state_q    <= state_d;
      baud_q     <= baud_d;
      bits_q     <= bits_d;
      shift_q    <= shift_d;
      par_err_q  <= par_err_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
    end
  end

  assign rx_data_out   = data_out_q;
  assign rx_data_valid = valid_q;
  assign rx_parity_err = perr_q;
  assign rx_frame_err  = ferr_q;
  assign rx_overrun    = ovr_q;
  assign rx_busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: odd- and even-parity receivers share one serial line,
// frames are driven bit-accurately and accepted words compared with expectations.
module tb_uart_rx;

  localparam int BIT_CNT = 16;

  logic       clock = 1'b0;
  logic       rst   = 1'b1;
  logic       line  = 1'b1;
  logic       ready = 1'b0;

  logic [7:0] o_data, e_data;
  logic       o_valid, o_perr, o_ferr, o_ovr, o_busy;
  logic       e_valid, e_perr, e_ferr, e_ovr, e_busy;

  int checks   = 0;
  int failures = 0;

  uart_rx #(.BAUD_RATE(1), .CLK_RATE(16), .WORD_WIDTH(8), .EVEN_PARITY(0)) u_odd (
    .clock(clock), .rst(rst), .rx_data_in(line), .rx_ready(ready),
    .rx_data_out(o_data), .rx_data_valid(o_valid), .rx_parity_err(o_perr),
    .rx_frame_err(o_ferr), .rx_overrun(o_ovr), .rx_busy(o_busy));

  uart_rx #(.BAUD_RATE(1), .CLK_RATE(16), .WORD_WIDTH(8), .EVEN_PARITY(1)) u_even (
    .clock(clock), .rst(rst), .rx_data_in(line), .rx_ready(ready),
    .rx_data_out(e_data), .rx_data_valid(e_valid), .rx_parity_err(e_perr),
    .rx_frame_err(e_ferr), .rx_overrun(e_ovr), .rx_busy(e_busy));

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] od;
    logic [7:0] ed;
    logic       op;
    logic       ep;
    logic       of;
    logic       ef;
    logic       oo;
  } cap_t;

  cap_t caps[$];
  int   vcycles = 0;

  // Words are recorded at the moment they are handed over (valid && ready).
  always @(negedge clock) begin
    if (!rst) begin
      if (o_valid) vcycles++;
      if (o_valid && ready)
        caps.push_back('{o_data, e_data, o_perr, e_perr, o_ferr, e_ferr, o_ovr});
    end
  end

  typedef struct {
    logic [7:0] d;
    logic       par;
    logic       stop;
    logic       exp_po;
    logic       exp_pe;
    logic       exp_fe;
  } vec_t;

  int cap_idx = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    line = b;
    cycles(BIT_CNT);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input int gap);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(stop);
    line = 1'b1;
    cycles(gap);
  endtask

  function automatic int ones(input logic [7:0] d);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(d[i]);
    return n;
  endfunction

  // Parity bit a correct transmitter would send: total number of ones odd / even.
  function automatic logic odd_bit(input logic [7:0] d);
    return (ones(d) % 2) == 0;
  endfunction

  function automatic logic even_bit(input logic [7:0] d);
    return (ones(d) % 2) == 1;
  endfunction

  task automatic take_capture(input string tag, input logic [7:0] d, input logic po,
                              input logic pe, input logic fe, input logic ov);
    int waited = 0;
    cap_t c;
    while (caps.size() <= cap_idx && waited < 400) begin
      cycles(1);
      waited++;
    end
    check({tag, "_delivered"}, caps.size() > cap_idx, 1);
    if (caps.size() > cap_idx) begin
      c = caps[cap_idx];
      cap_idx++;
      check({tag, "_data_odd"}, c.od, d);
      check({tag, "_data_even"}, c.ed, d);
      check({tag, "_perr_odd"}, c.op, po);
      check({tag, "_perr_even"}, c.ep, pe);
      check({tag, "_ferr_odd"}, c.of, fe);
      check({tag, "_ferr_even"}, c.ef, fe);
      check({tag, "_overrun"}, c.oo, ov);
    end
  endtask

  task automatic expect_model(input string tag, input logic [7:0] d, input logic par,
                              input logic stop, input logic ov);
    take_capture(tag, d, par != odd_bit(d), par != even_bit(d), !stop, ov);
  endtask

  vec_t table_v[7];
  int   v0;

  initial begin
    table_v[0] = '{8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    table_v[1] = '{8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    table_v[2] = '{8'h55, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    table_v[3] = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    table_v[4] = '{8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    table_v[5] = '{8'h80, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    table_v[6] = '{8'h01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    rst = 1'b1; line = 1'b1; ready = 1'b0;
    cycles(4);
    check("reset_odd", {o_data, o_valid, o_perr, o_ferr, o_ovr, o_busy}, 0);
    check("reset_even", {e_data, e_valid, e_perr, e_ferr, e_ovr, e_busy}, 0);
    rst = 1'b0;
    cycles(4);

    ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      v0 = vcycles;
      send_frame(table_v[i].d, table_v[i].par, table_v[i].stop, 20);
      take_capture($sformatf("vec%0d", i), table_v[i].d, table_v[i].exp_po,
                   table_v[i].exp_pe, table_v[i].exp_fe, 1'b0);
      check($sformatf("vec%0d_valid_cycles", i), vcycles - v0, 1);
      check($sformatf("vec%0d_busy_after", i), o_busy, 0);
    end

    // Stop bit low and the line stays low: no new frame may start.
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(i % 2 == 0);
    send_bit(1'b1);
    send_bit(1'b0);
    cycles(2 * BIT_CNT);
    check("ferr_hold_busy", o_busy, 0);
    check("ferr_hold_words", caps.size() - cap_idx, 1);
    take_capture("ferr_hold", 8'h55, 1'b0, 1'b1, 1'b1, 1'b0);
    line = 1'b1;
    cycles(10);
    check("ferr_release_busy", o_busy, 0);

    // Glitch shorter than half a bit.
    v0 = vcycles;
    line = 1'b0;
    cycles(4);
    check("glitch_started", o_busy, 1);
    line = 1'b1;
    cycles(30);
    check("glitch_idle", o_busy, 0);
    check("glitch_no_valid", vcycles - v0, 0);
    check("glitch_no_word", caps.size() - cap_idx, 0);

    // Overrun.
    ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b1, 0);
    check("ovr_first_valid", o_valid, 1);
    check("ovr_first_flag", o_ovr, 0);
    send_frame(8'h22, 1'b1, 1'b1, 4);
    check("ovr_held_valid", o_valid, 1);
    check("ovr_held_data", o_data, 8'h11);
    check("ovr_flag_odd", o_ovr, 1);
    check("ovr_flag_even", e_ovr, 1);
    ready = 1'b1;
    cycles(1);
    ready = 1'b0;
    check("ovr_accept_valid", o_valid, 0);
    check("ovr_accept_flag", o_ovr, 0);
    take_capture("ovr_word", 8'h11, 1'b0, 1'b1, 1'b0, 1'b1);
    ready = 1'b1;
    send_frame(8'h33, 1'b1, 1'b1, 20);
    take_capture("after_ovr", 8'h33, 1'b0, 1'b1, 1'b0, 1'b0);

    // Reset in the middle of data bit 3, with a word held on the output.
    ready = 1'b0;
    send_frame(8'h0F, 1'b1, 1'b1, 4);
    check("pre_rst_valid", o_valid, 1);
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    line = 1'b1;
    cycles(BIT_CNT / 2);
    check("pre_rst_busy", o_busy, 1);
    rst = 1'b1;
    cycles(2);
    check("mid_rst_odd", {o_data, o_valid, o_perr, o_ferr, o_ovr, o_busy}, 0);
    check("mid_rst_even", {e_data, e_valid, e_perr, e_ferr, e_ovr, e_busy}, 0);
    rst = 1'b0;
    cycles(6 * BIT_CNT);
    check("post_rst_busy", o_busy, 0);
    check("post_rst_valid", o_valid, 0);
    ready = 1'b1;
    send_frame(8'h81, 1'b1, 1'b1, 20);
    take_capture("post_rst", 8'h81, 1'b0, 1'b1, 1'b0, 1'b0);

    // Random frames against the parity/framing model.
    for (int i = 0; i < 12; i++) begin
      logic [7:0] d;
      logic       par, stop;
      int         gap;
      d    = 8'($urandom_range(0, 255));
      par  = 1'($urandom_range(0, 1));
      stop = ($urandom_range(0, 3) != 0);
      gap  = $urandom_range(2, 20);
      send_frame(d, par, stop, gap);
      expect_model($sformatf("rand%0d", i), d, par, stop, 1'b0);
      check($sformatf("rand%0d_busy", i), o_busy, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Asynchronous serial receiver; the far end of the team's UART transmitter link.
- Frame format: 1 start bit (0), WORD_WIDTH data bits LSB first, 1 parity bit, 1 stop bit (1). The transmitter's extra idle bit after stop is seen as ordinary line idle.
- Samples the synchronised line at mid-bit and presents each received word on a valid/ready output register, with parity, framing and overrun flags.

Parameters:
- BAUD_RATE, 115200, serial bit rate.
- CLK_RATE, 100000000, clock frequency in Hz.
- WORD_WIDTH, 8, data bits per frame.
- EVEN_PARITY, 0, 1 = even parity; 0 = odd parity.

Ports:
- clock  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rx_data_in  in  1  serial line; asynchronous, idles high
- rx_ready  in  1  consumer accepts the word when high together with rx_data_valid
- rx_data_out  out  WORD_WIDTH  received word
- rx_data_valid  out  1  rx_data_out and flags hold a word not yet accepted
- rx_parity_err  out  1  parity mismatch on the held word
- rx_frame_err  out  1  stop bit sampled 0 on the held word
- rx_overrun  out  1  a completed frame was dropped because the held word was not accepted
- rx_busy  out  1  FSM not in IDLE

Behaviour:
- Reset and clock: reset rst, synchronous, active-high; clock clock. On reset, FSM=IDLE, counters=0, synchroniser flops=1. All outputs are 0.
- Constants:
  - BIT_CNT = CLK_RATE/BAUD_RATE, integer division.
  - HALF_CNT = BIT_CNT/2.
  - Counter widths are $clog2 of their maximum.
- Input path: 2-flop synchroniser, plus a third flop used for edge detection. Synchroniser latency is 2 cycles.
- Start detection: a falling edge on the synchronised line (prev=1, cur=0). A line held low never re-triggers; the line must return high first.
- FSM:
  - IDLE: on falling edge -> START. Baud counter cleared.
  - START: count HALF_CNT cycles, then sample.
    - Sample 0 -> DATA, baud counter cleared, bit counter = 0.
    - Sample 1 -> IDLE (glitch rejected, no output).
  - DATA: every BIT_CNT cycles, sample and shift into the MSB of the shift register (right shift), so the first bit ends at bit 0.
    - After WORD_WIDTH samples -> PARITY.
  - PARITY: after BIT_CNT cycles, sample the parity bit.
    - Expected parity = EVEN_PARITY ? ^data : ~^data.
    - Store mismatch -> STOP.
  - STOP: after BIT_CNT cycles, sample the stop bit.
    - frame_err = (sample == 0).
    - Return to IDLE in the same cycle as the sample, i.e. at mid-stop-bit, so the receiver is re-armed for back-to-back frames.
- Output register:
  - Loaded on the clock after the stop-bit sample when rx_data_valid=0, or when rx_data_valid=1 and rx_ready=1 in that same cycle.
  - Load action: rx_data_out, rx_parity_err and rx_frame_err are updated; rx_data_valid=1.
  - Words with errors are still delivered; the flags qualify them.
- Handshake:
  - rx_data_valid stays high until a cycle with rx_data_valid && rx_ready.
  - On accept, rx_data_valid=0 on the next clock, unless a new load occurs that same cycle.
  - rx_data_out and flags are stable while rx_data_valid=1.
- Overrun:
  - If a frame completes while rx_data_valid=1 and rx_ready=0, the new word is discarded and the held word is kept.
  - rx_overrun is set and stays set until the next accept handshake, which clears it.
- Latency: rx_data_valid rises 1 clock after the stop-bit sample. That is about 2 + 10.5*BIT_CNT cycles after the start-bit falling edge on the pin.
- Reset mid-frame: FSM aborts to IDLE and all outputs clear. The remaining bits of the aborted frame cannot false-trigger unless a genuine 1->0 edge occurs after reset.
- rx_ready is ignored while rx_data_valid=0.

Test Plan:
- Bench setup: all scenarios use CLK_RATE=16, BAUD_RATE=1, giving BIT_CNT=16 and HALF_CNT=8. The line is driven by a bit-accurate model or by the team's transmitter in loopback.
- Good frame: 0xA5, parity bit 1 (odd), stop 1, rx_ready=1 -> rx_data_valid for 1 cycle, rx_data_out=0xA5, both error flags 0, rx_busy low after mid-stop.
- Bad parity: 0x3C sent with parity bit 0 (odd expects 1) -> rx_data_out=0x3C, rx_parity_err=1, rx_frame_err=0. Repeat with EVEN_PARITY=1 and parity 0 -> rx_parity_err=0.
- Framing error: 0x55 with stop bit 0, then line high -> rx_frame_err=1, data 0x55. No new frame starts until the line has gone high and then falls again.
- Glitch: line low for 4 cycles (< HALF_CNT) then high -> FSM returns to IDLE, rx_data_valid stays 0.
- Overrun: frames 0x11 then 0x22 back-to-back with rx_ready=0 -> rx_data_out=0x11 held, rx_overrun=1 after the second frame. Raise rx_ready -> accepted, rx_data_valid=0, rx_overrun=0. Next frame 0x33 is received cleanly.
- Reset mid-DATA: assert rst during bit 3 of 0xFF -> all outputs 0, FSM IDLE. A following frame 0x81 is received correctly with no errors.
